delay_line_tank: RTL
====================

// Module: delay_line_tank
// PURPOSE
//  Parametrised model of one mercury delay-line tank: a recirculating serial store of WORDS
//  short-word slots of DIGITS digits each, one digit per clk.
//  Replaces hand-wired per-tank up/down in/out/clr signals with one req/ack port per tank.
//  Adds clear, long-word (slot pair) mode, digit-pulse sync checking and a monitor tap.
//  memory_top instantiates one per tank; computer accesses it through the req/ack port.
// PARAMETERS
//  DIGITS  18  digit periods per short-word slot (minor cycle); >=2
//  WORDS   16  short-word slots per tank (major cycle = WORDS*DIGITS clk); even, power of 2
//  ADDR_W  $clog2(WORDS)  width of word_sel; derived, not overridden
// PORTS
//  clk       in   1       system clock; one digit period per cycle
//  rst_n     in   1       asynchronous reset, active low
//  d0        in   1       digit-pulse-generator start-of-minor-cycle pulse
//  req       in   1       access request; level, held with op/word_sel/long until ack
//  op        in   2       edsac_pkg::tank_op_t: READ=0, WRITE=1, CLEAR=2 (3 reserved = READ)
//  long_w    in   1       1 = long word: slot pair {word_sel[ADDR_W-1:1],0}/{..,1}
//  word_sel  in   ADDR_W  target short-word slot
//  mib       in   1       serial write data, LSB first, sampled during XFER
//  mob       out  1       serial read data, LSB first, valid during XFER of READ
//  busy      out  1       state != IDLE
//  ack       out  1       one-cycle pulse: access complete
//  mon       out  1       recirculating stream tap (sr[0]) for CRT monitor
//  sync_err  out  1       sticky: d0 seen when digit_cnt != 0
// BEHAVIOUR
//  Reset (async, rst_n=0): storage all 0, digit_cnt=0, word_cnt=0, state IDLE; outputs mob=0,
//    busy=0, ack=0, mon=0, sync_err=0. Reset mid-access: access dropped, no ack.
//  Storage: N=WORDS*DIGITS-bit circular shift register. Each clk: sr <= {next_in, sr[N-1:1]}.
//    next_in = mib in WRITE XFER, 0 in CLEAR XFER, else sr[0] (recirculate).
//  Position: digit_cnt 0..DIGITS-1 wraps to 0 and increments word_cnt (mod WORDS).
//    Cycle with digit_cnt=k, word_cnt=w presents digit k of slot w at sr[0].
//  Sync: d0=1 with digit_cnt!=0 -> sync_err<=1 (sticky until reset); digit_cnt<=1 next cycle
//    (realign to d0 phase); word_cnt unchanged. d0 with digit_cnt=0: no effect.
//  FSM IDLE->WAIT->XFER->DONE->IDLE:
//    IDLE: req=1 -> latch op/long_w/word_sel, go WAIT. Inputs ignored outside IDLE.
//    WAIT: start slot = word_sel (short) or {word_sel[ADDR_W-1:1],0} (long); when digit_cnt=0
//      and word_cnt=start slot -> XFER that same cycle (this is first XFER digit).
//      Request accepted exactly at slot start -> waits one full major cycle.
//    XFER: DIGITS cycles (2*DIGITS if long); mob=sr[0] if READ else 0.
//      WRITE: mib this cycle becomes that digit. After last digit -> DONE.
//    DONE: ack=1 for one cycle -> IDLE. req may remain high; new access needs req re-sampled in IDLE.
//  Latency req->ack: min DIGITS+2 cycles (short), max N+DIGITS+1 (short) / N+2*DIGITS+1 (long).
//  mob=0 in all states except READ XFER; mon always sr[0].
//  Realign during WAIT/XFER: counters jump; in-flight XFER continues by cycle count (not slot);
//    sync_err flags the corruption.
// STRUCTURE
//  edsac_pkg: tank_op_t enum, DIGITS_SHORT=18, TANK_WORDS=16 constants.
//  Sub-module tank_position_counter (digit_cnt/word_cnt, d0 realign, sync_err); FSM and
//    shift register in this module.
// TESTING (DIGITS=18, WORDS=16, N=288; d0 every 18 clk from generator)
//  WRITE slot 5 data 0x2A5A5 LSB first, then READ slot 5 -> mob stream 0x2A5A5; other slots 0.
//  WRITE slot 3, CLEAR slot 3, READ slot 3 -> mob all 0, ack each; slots 2/4 unchanged.
//  long_w WRITE word_sel=7 (slots 6,7) 36-bit 0x9_1234_5678 -> READ long 6 returns same;
//    short READ 6 -> low 18 bits, slot 7 -> high 18 bits.
//  req at digit_cnt=0, word_cnt=slot -> ack at +N+DIGITS+1 cycles; req one cycle earlier ->
//    ack at +DIGITS+2.
//  Extra d0 at digit_cnt=9 -> sync_err=1 and stays 1; digit_cnt=1 next cycle.
//  rst_n low mid-WRITE XFER -> no ack, busy=0, all storage reads 0 after release.

Source files
------------

// File: rtl/delay_line_tank_pkg.sv
// Shared types and default geometry for the mercury delay-line tank model.
package edsac_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_CLEAR = 2'd2,
    OP_RSVD  = 2'd3
  } tank_op_t;

  localparam int unsigned DIGITS_SHORT = 18;
  localparam int unsigned TANK_WORDS   = 16;

  // Any op that is neither WRITE nor CLEAR behaves as READ.
  function automatic logic op_is_read(input tank_op_t op);
    return (op != OP_WRITE) && (op != OP_CLEAR);
  endfunction

endpackage

// File: rtl/delay_line_tank_if.sv
// Per-tank request/acknowledge port with serial data in/out.
interface delay_line_tank_if #(
  parameter int unsigned WORDS = edsac_pkg::TANK_WORDS
);
  import edsac_pkg::*;

  localparam int unsigned ADDR_W = $clog2(WORDS);

  logic              req;
  tank_op_t          op;
  logic              long_w;
  logic [ADDR_W-1:0] word_sel;
  logic              mib;
  logic              mob;
  logic              busy;
  logic              ack;

  modport master (
    output req, op, long_w, word_sel, mib,
    input  mob, busy, ack
  );

  modport slave (
    input  req, op, long_w, word_sel, mib,
    output mob, busy, ack
  );

endinterface

// File: rtl/delay_line_tank_position_counter.sv
// Digit/word position within the major cycle, realigned by the digit-pulse generator.
module tank_position_counter #(
  parameter  int unsigned DIGITS = 18,
  parameter  int unsigned WORDS  = 16,
  localparam int unsigned DW     = $clog2(DIGITS),
  localparam int unsigned AW     = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          d0_i,
  output logic [DW-1:0] digit_cnt_o,
  output logic [AW-1:0] word_cnt_o,
  output logic          sync_err_o
);

  logic [DW-1:0] digit_q, digit_d;
  logic [AW-1:0] word_q, word_d;
  logic          err_q, err_d;

  always_comb begin
    digit_d = digit_q;
    word_d  = word_q;
    err_d   = err_q;
    // A d0 off phase means this cycle should have been digit 0; the word count is kept.
    if (d0_i && (digit_q != '0)) begin
      err_d   = 1'b1;
      digit_d = DW'(1);
    end else if (digit_q == DW'(DIGITS - 1)) begin
      digit_d = '0;
      word_d  = word_q + 1'b1;
    end else begin
      digit_d = digit_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      digit_q <= digit_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

  assign digit_cnt_o = digit_q;
  assign word_cnt_o  = word_q;
  assign sync_err_o  = err_q;

endmodule

// File: rtl/delay_line_tank.sv
// One recirculating delay-line tank: WORDS slots of DIGITS serial digits,
// accessed slot-synchronously through a req/ack port.
module delay_line_tank
  import edsac_pkg::*;
#(
  parameter int unsigned DIGITS = DIGITS_SHORT,
  parameter int unsigned WORDS  = TANK_WORDS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     d0,
  delay_line_tank_if.slave         bus,
  output logic                     mon,
  output logic                     sync_err
);

  localparam int unsigned ADDR_W = $clog2(WORDS);
  localparam int unsigned N      = WORDS * DIGITS;
  localparam int unsigned DW     = $clog2(DIGITS);
  localparam int unsigned LW     = $clog2(2 * DIGITS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [DW-1:0]     digit_cnt;
  logic [ADDR_W-1:0] word_cnt;

  tank_position_counter #(
    .DIGITS (DIGITS),
    .WORDS  (WORDS)
  ) u_pos (
    .clk         (clk),
    .rst_n       (rst_n),
    .d0_i        (d0),
    .digit_cnt_o (digit_cnt),
    .word_cnt_o  (word_cnt),
    .sync_err_o  (sync_err)
  );

  logic [1:0]        state_q, state_d;
  tank_op_t          op_q, op_d;
  logic              long_q, long_d;
  logic [ADDR_W-1:0] sel_q, sel_d;
  logic [LW-1:0]     xcnt_q, xcnt_d;
  logic [N-1:0]      sr_q, sr_d;

  logic [ADDR_W-1:0] start_slot;
  logic [LW-1:0]     last_idx;
  logic              slot_hit;
  logic              xfer_now;
  logic              next_in;

  always_comb begin
    start_slot = long_q ? (sel_q & ~ADDR_W'(1)) : sel_q;
    last_idx   = long_q ? LW'(2 * DIGITS - 1) : LW'(DIGITS - 1);
    slot_hit   = (digit_cnt == '0) && (word_cnt == start_slot);
    // The matching WAIT cycle already carries digit 0 of the transfer.
    xfer_now   = (state_q == S_XFER) || ((state_q == S_WAIT) && slot_hit);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    long_d  = long_q;
    sel_d   = sel_q;
    xcnt_d  = xcnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          op_d    = bus.op;
          long_d  = bus.long_w;
          sel_d   = bus.word_sel;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (slot_hit) begin
          xcnt_d  = LW'(1);
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (xcnt_q == last_idx) begin
          xcnt_d  = '0;
          state_d = S_DONE;
        end else begin
          xcnt_d = xcnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    next_in = sr_q[0];
    if (xfer_now && (op_q == OP_WRITE)) begin
      next_in = bus.mib;
    end else if (xfer_now && (op_q == OP_CLEAR)) begin
      next_in = 1'b0;
    end
    sr_d = {next_in, sr_q[N-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_READ;
      long_q  <= 1'b0;
      sel_q   <= '0;
      xcnt_q  <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      long_q  <= long_d;
      sel_q   <= sel_d;
      xcnt_q  <= xcnt_d;
      sr_q    <= sr_d;
    end
  end

  assign bus.mob  = (xfer_now && op_is_read(op_q)) ? sr_q[0] : 1'b0;
  assign bus.busy = (state_q != S_IDLE);
  assign bus.ack  = (state_q == S_DONE);
  assign mon      = sr_q[0];

endmodule
